param_compress_unit: RTL and testbench

Parametrised successor to the eight-lane compress unit. Accepts one block of LANES words of WIDTH bits per transfer, classifies each word into a 2-bit size tag, packs the significant portions contiguously from the LSB, and reports the packed length in quarter-word units. Unlike the fixed eight-lane unit, it is pipelined with a valid/ready handshake on both sides and has a per-block raw bypass mode. It sits between the block source and the compressed-stream writer.

---
 rtl/param_compress_unit_if.sv | 30 +++
 rtl/param_compress_unit.sv | 134 +++++++++++++
 tb/tb_param_compress_unit.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_compress_unit_if.sv
// Block-level handshake bundle for param_compress_unit.
// The slave modport is the compress unit; the master modport is whoever
// feeds blocks in and drains packed blocks out.
interface param_compress_unit_if #(
  parameter int LANES = 8,
  parameter int WIDTH = 32,
  parameter int LEN_W = $clog2(4 * LANES + 1)
) ();

  logic                   validIn;
  logic                   readyOut;
  logic                   bypassIn;
  logic [LANES*WIDTH-1:0] dataIn;
  logic [LANES*WIDTH-1:0] dataOut;
  logic [2*LANES-1:0]     tagOut;
  logic [LEN_W-1:0]       lenOut;
  logic                   validOut;
  logic                   readyIn;

  modport slave (
    input  validIn, bypassIn, dataIn, readyIn,
    output readyOut, dataOut, tagOut, lenOut, validOut
  );

  modport master (
    output validIn, bypassIn, dataIn, readyIn,
    input  readyOut, dataOut, tagOut, lenOut, validOut
  );

endinterface

// File: rtl/param_compress_unit.sv
// Two-stage block compressor: stage 1 classifies each lane into a size tag
// and computes its packed offset, stage 2 shifts and ORs the lanes into a
// contiguous LSB-aligned payload. Valid/ready on both sides, no skid buffer.
module param_compress_unit #(
  parameter int LANES = 8,
  parameter int WIDTH = 32,
  parameter int LEN_W = $clog2(4 * LANES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  param_compress_unit_if.slave  bus
);

  localparam int Q     = WIDTH / 4;
  localparam int BUS_W = LANES * WIDTH;

  localparam logic [WIDTH-1:0] MASK1 = {{(WIDTH - Q){1'b0}}, {Q{1'b1}}};
  localparam logic [WIDTH-1:0] MASK2 = {{(WIDTH - 2 * Q){1'b0}}, {(2 * Q){1'b1}}};

  // Stage 1 next-state (combinational) and registers.
  logic [LANES-1:0][1:0]       tagNext,  s1Tag;
  logic [LANES-1:0][2:0]       sizeNext, s1Size;
  logic [LANES-1:0][LEN_W-1:0] offNext,  s1Off;
  logic [LANES-1:0][WIDTH-1:0] wordNext, s1Word;
  logic                        s1Valid;

  // Stage 2 next-state (combinational) and registers.
  logic [BUS_W-1:0]   packNext, dataOutQ;
  logic [LEN_W-1:0]   lenNext,  lenOutQ;
  logic [2*LANES-1:0] tagOutQ;
  logic               validOutQ;

  logic s1En, s2En;

  // A stage may advance when it is empty or the stage after it advances.
  assign s2En         = !validOutQ || bus.readyIn;
  assign s1En         = !s1Valid || s2En;
  assign bus.readyOut = s1En;

  assign bus.dataOut  = dataOutQ;
  assign bus.tagOut   = tagOutQ;
  assign bus.lenOut   = lenOutQ;
  assign bus.validOut = validOutQ;

  // Classify each incoming lane and build the running offset of its packed slot.
  always_comb begin
    logic [WIDTH-1:0] w;
    int               acc;
    w        = '0;
    acc      = 0;
    tagNext  = '0;
    sizeNext = '0;
    offNext  = '0;
    wordNext = '0;
    for (int i = 0; i < LANES; i++) begin
      w = bus.dataIn[i*WIDTH +: WIDTH];
      if (bus.bypassIn) begin
        tagNext[i]  = 2'b11;
        sizeNext[i] = 3'd4;
        wordNext[i] = w;
      end else if (w == '0) begin
        tagNext[i]  = 2'b00;
        sizeNext[i] = 3'd0;
        wordNext[i] = '0;
      end else if (w[WIDTH-1:Q] == '0) begin
        tagNext[i]  = 2'b01;
        sizeNext[i] = 3'd1;
        wordNext[i] = w & MASK1;
      end else if (w[WIDTH-1:2*Q] == '0) begin
        tagNext[i]  = 2'b10;
        sizeNext[i] = 3'd2;
        wordNext[i] = w & MASK2;
      end else begin
        tagNext[i]  = 2'b11;
        sizeNext[i] = 3'd4;
        wordNext[i] = w;
      end
      offNext[i] = LEN_W'(acc);
      acc        = acc + int'(sizeNext[i]);
    end
  end

  // Shift-and-OR packing network from the stage 1 registers.
  always_comb begin
    logic [BUS_W-1:0] lane;
    lane     = '0;
    packNext = '0;
    for (int i = 0; i < LANES; i++) begin
      lane              = '0;
      lane[WIDTH-1:0]   = s1Word[i];
      packNext          = packNext | (lane << (int'(s1Off[i]) * Q));
    end
    lenNext = s1Off[LANES-1] + LEN_W'(s1Size[LANES-1]);
  end

  // Stage 1: capture a block on an input transfer, otherwise fill with a bubble.
  // NOTE: state uses non-blocking assignments so both stages see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: data registers are reset too, so outputs read 0 straight after reset.
      s1Valid <= 1'b0;
      s1Tag   <= '0;
      s1Size  <= '0;
      s1Off   <= '0;
      s1Word  <= '0;
    end else if (s1En) begin
      s1Valid <= bus.validIn;
      if (bus.validIn) begin
        s1Tag  <= tagNext;
        s1Size <= sizeNext;
        s1Off  <= offNext;
        s1Word <= wordNext;
      end
    end
  end

  // Stage 2: register the packed block; bubbles leave held data untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      validOutQ <= 1'b0;
      dataOutQ  <= '0;
      tagOutQ   <= '0;
      lenOutQ   <= '0;
    end else if (s2En) begin
      validOutQ <= s1Valid;
      if (s1Valid) begin
        dataOutQ <= packNext;
        tagOutQ  <= s1Tag;
        lenOutQ  <= lenNext;
      end
    end
  end

endmodule

// File: tb/tb_param_compress_unit.sv
// Self-checking bench for param_compress_unit: directed scenarios plus
// randomized traffic scored against a bit-level packing model.
module tb_param_compress_unit;

  typedef struct packed {
    logic [255:0] d;
    logic [15:0]  t;
    logic [5:0]   l;
  } expT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  param_compress_unit_if #(.LANES(8), .WIDTH(32)) bus ();
  param_compress_unit #(.LANES(8), .WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  param_compress_unit_if #(.LANES(4), .WIDTH(16)) busS ();
  param_compress_unit #(.LANES(4), .WIDTH(16)) dutS (
    .clk   (clk),
    .reset (reset),
    .bus   (busS.slave)
  );

  int  checks   = 0;
  int  failures = 0;
  int  nIn      = 0;
  int  nOut     = 0;
  expT expQ[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: walk lanes, pick a size from the value range, copy bits serially.
  function automatic expT model(input logic [255:0] d, input logic byp);
    expT         e;
    int          pos;
    int          sz;
    logic [31:0] w;
    e   = '0;
    pos = 0;
    for (int i = 0; i < 8; i++) begin
      w = d[i*32 +: 32];
      if (byp)                sz = 4;
      else if (w == 0)        sz = 0;
      else if (w < 32'h100)   sz = 1;
      else if (w < 32'h10000) sz = 2;
      else                    sz = 4;
      e.t[2*i +: 2] = (sz == 4) ? 2'd3 : 2'(sz);
      for (int b = 0; b < sz * 8; b++) e.d[pos*8 + b] = w[b];
      pos += sz;
    end
    e.l = 6'(pos);
    return e;
  endfunction

  function automatic logic [31:0] randWord();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'($urandom_range(1, 255));
      2:       return 32'($urandom_range(256, 65535));
      default: return $urandom | 32'h0001_0000;
    endcase
  endfunction

  function automatic logic [255:0] randBlock();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = randWord();
    return r;
  endfunction

  // One clock: score transfers seen just before the edge, then advance to the next negedge.
  task automatic tick(output bit accepted);
    bit  inX, outX;
    expT e;
    #1;
    inX  = bus.validIn && bus.readyOut && !reset;
    outX = bus.validOut && bus.readyIn && !reset;
    if (outX) begin
      check("queue_has_entry", 256'(expQ.size() != 0), 256'(1));
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        check("sb_data", bus.dataOut, e.d);
        check("sb_tag", 256'(bus.tagOut), 256'(e.t));
        check("sb_len", 256'(bus.lenOut), 256'(e.l));
        nOut++;
      end
    end
    if (inX) begin
      expQ.push_back(model(bus.dataIn, bus.bypassIn));
      nIn++;
    end
    accepted = inX;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tk();
    bit a;
    tick(a);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.validIn = 1'b0;
    bus.readyIn = 1'b1;
    while (expQ.size() != 0 && n < 50) begin
      tk();
      n++;
    end
    check("drain_done", 256'(expQ.size()), 256'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] mixed, ones, held;
    logic [15:0]  heldTag;
    logic [5:0]   heldLen;
    logic [255:0] bp[6];
    int           idx, dropped;
    bit           acc;

    mixed = {32'h0, 32'h0, 32'h0, 32'hFEDCBA98, 32'h0000_8765, 32'h0000_0043, 32'h0, 32'h0000_0021};
    ones  = {256{1'b1}};

    bus.validIn  = 1'b0;
    bus.bypassIn = 1'b0;
    bus.dataIn   = '0;
    bus.readyIn  = 1'b1;
    busS.validIn  = 1'b0;
    busS.bypassIn = 1'b0;
    busS.dataIn   = '0;
    busS.readyIn  = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", 256'(bus.validOut), 256'(0));
    check("rst_data", bus.dataOut, 256'(0));
    check("rst_tag", 256'(bus.tagOut), 256'(0));
    check("rst_len", 256'(bus.lenOut), 256'(0));
    check("rst_ready", 256'(bus.readyOut), 256'(1));
    @(negedge clk);
    reset = 1'b0;

    // Mixed block: latency and spec values.
    bus.validIn = 1'b1;
    bus.dataIn  = mixed;
    tk();
    bus.validIn = 1'b0;
    #1;
    check("lat_not_yet", 256'(bus.validOut), 256'(0));
    tk();
    #1;
    check("lat_valid", 256'(bus.validOut), 256'(1));
    check("mixed_tag", 256'(bus.tagOut), 256'(16'h0391));
    check("mixed_len", 256'(bus.lenOut), 256'(8));
    check("mixed_data", bus.dataOut, 256'(64'hFEDCBA98_87654321));
    drain();

    // All-zero then all-ones back to back.
    bus.validIn = 1'b1;
    bus.dataIn  = '0;
    tk();
    bus.dataIn  = ones;
    tk();
    bus.validIn = 1'b0;
    #1;
    check("zero_tag", 256'(bus.tagOut), 256'(0));
    check("zero_len", 256'(bus.lenOut), 256'(0));
    check("zero_data", bus.dataOut, 256'(0));
    tk();
    #1;
    check("ones_tag", 256'(bus.tagOut), 256'(16'hFFFF));
    check("ones_len", 256'(bus.lenOut), 256'(32));
    check("ones_data", bus.dataOut, ones);
    drain();

    // Bypass on the mixed block.
    bus.validIn  = 1'b1;
    bus.bypassIn = 1'b1;
    bus.dataIn   = mixed;
    tk();
    bus.validIn  = 1'b0;
    bus.bypassIn = 1'b0;
    tk();
    #1;
    check("byp_tag", 256'(bus.tagOut), 256'(16'hFFFF));
    check("byp_len", 256'(bus.lenOut), 256'(32));
    check("byp_data", bus.dataOut, mixed);
    drain();

    // Alternating bypass across 4 back-to-back blocks.
    for (int i = 0; i < 4; i++) begin
      bus.validIn  = 1'b1;
      bus.bypassIn = i[0];
      bus.dataIn   = (i < 2) ? mixed : randBlock();
      tk();
    end
    bus.bypassIn = 1'b0;
    drain();

    // Backpressure: 6 blocks, readyIn low for 3 cycles after first output.
    for (int i = 0; i < 6; i++) bp[i] = randBlock();
    idx = 0;
    held = '0;
    heldTag = '0;
    heldLen = '0;
    for (int c = 0; c < 60 && (idx < 6 || expQ.size() != 0); c++) begin
      bus.validIn = (idx < 6);
      bus.dataIn  = (idx < 6) ? bp[idx] : '0;
      bus.readyIn = !(c >= 2 && c <= 4);
      #1;
      if (c == 2) begin
        check("bp_first_out", 256'(bus.validOut), 256'(1));
        held    = bus.dataOut;
        heldTag = bus.tagOut;
        heldLen = bus.lenOut;
      end
      if (c >= 2 && c <= 4) begin
        check("bp_ready_low", 256'(bus.readyOut), 256'(0));
        check("bp_hold_data", bus.dataOut, held);
        check("bp_hold_tag", 256'(bus.tagOut), 256'(heldTag));
        check("bp_hold_len", 256'(bus.lenOut), 256'(heldLen));
      end
      tick(acc);
      if (acc) idx++;
    end
    check("bp_all_sent", 256'(idx), 256'(6));
    drain();

    // Reset with 2 blocks in flight, plus a simultaneous input.
    bus.readyIn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.validIn = 1'b1;
      bus.dataIn  = randBlock();
      tk();
    end
    reset       = 1'b1;
    bus.dataIn  = randBlock();
    @(posedge clk);
    @(negedge clk);
    reset       = 1'b0;
    bus.validIn = 1'b0;
    dropped = expQ.size();
    nIn -= dropped;
    expQ.delete();
    #1;
    check("mrst_valid", 256'(bus.validOut), 256'(0));
    check("mrst_data", bus.dataOut, 256'(0));
    check("mrst_tag", 256'(bus.tagOut), 256'(0));
    check("mrst_len", 256'(bus.lenOut), 256'(0));
    check("mrst_ready", 256'(bus.readyOut), 256'(1));
    for (int i = 0; i < 2; i++) begin
      bus.validIn = 1'b1;
      bus.dataIn  = randBlock();
      tk();
    end
    drain();

    // Randomized traffic with random backpressure and bypass.
    for (int c = 0; c < 200; c++) begin
      bus.validIn  = ($urandom_range(0, 9) < 7);
      bus.bypassIn = ($urandom_range(0, 3) == 0);
      bus.dataIn   = randBlock();
      bus.readyIn  = ($urandom_range(0, 9) < 7);
      tk();
    end
    bus.bypassIn = 1'b0;
    drain();
    check("in_out_count", 256'(nOut), 256'(nIn));

    // LANES=4, WIDTH=16 instance.
    busS.validIn = 1'b1;
    busS.dataIn  = {16'h0000, 16'h0C00, 16'h00B0, 16'h000A};
    @(posedge clk);
    @(negedge clk);
    busS.validIn = 1'b0;
    #1;
    check("small_not_yet", 256'(busS.validOut), 256'(0));
    @(posedge clk);
    @(negedge clk);
    #1;
    check("small_valid", 256'(busS.validOut), 256'(1));
    check("small_tag", 256'(busS.tagOut), 256'(8'b00111001));
    check("small_len", 256'(busS.lenOut), 256'(7));
    check("small_data", 256'(busS.dataOut), 256'(64'h0000_0000_0C00_B0A));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
